// File: rtl/dmem_ctrl.sv
// Fixed-latency data-memory responder for the EX/MEM stage.
// Handles RV32I byte/half/word loads and stores with a ready handshake.
module dmem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        funct3,
    output logic              mem_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW+1:0]     r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_f3;
    logic              r_rd;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [IW-1:0]     w_idx;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_ld;
    logic [DATA_W-1:0] w_wr_word;
    logic [7:0]        w_b;
    logic [15:0]       w_h;
    logic              w_byte;
    logic              w_half;
    logic              w_mis;
    logic              w_fire;
    logic              w_unused;

    // Address bits above the store size wrap and are never latched.
    assign w_unused = ^addr[ADDR_W-1:IW+2];

    assign w_idx  = r_addr[IW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = (r_f3[1:0] == 2'b00);
    assign w_half = (r_f3[1:0] == 2'b01);
    assign w_b    = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_h    = w_word[{r_addr[1], 4'b0000} +: 16];
    assign w_fire = (r_state == BUSY) && (r_cnt == '0);

    always_comb begin
        w_mis     = 1'b0;
        w_ld      = w_word;
        w_wr_word = w_word;
        unique case (1'b1)
            w_byte: begin
                w_ld = r_f3[2] ? {24'd0, w_b} : {{24{w_b[7]}}, w_b};
                w_wr_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            w_half: begin
                w_mis = r_addr[0];
                w_ld  = r_f3[2] ? {16'd0, w_h} : {{16{w_h[15]}}, w_h};
                w_wr_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: begin
                w_mis     = (r_addr[1:0] != 2'b00);
                w_wr_word = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_f3       <= '0;
            r_rd       <= 1'b0;
            mem_ready  <= 1'b1;
            rdata      <= '0;
            misaligned <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        r_state   <= BUSY;
                        r_rd      <= mem_read;
                        r_addr    <= addr[IW+1:0];
                        r_wdata   <= wdata;
                        r_f3      <= funct3;
                        r_cnt     <= CW'(LATENCY - 1);
                        mem_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state    <= DONE;
                        mem_ready  <= 1'b1;
                        misaligned <= w_mis;
                        if (r_rd) rdata <= w_mis ? '0 : w_ld;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    misaligned <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The array is not reset; an async reset leaves r_state in IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (w_fire && !r_rd && !w_mis) r_mem[w_idx] <= w_wr_word;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized and directed bench for dmem_ctrl against a byte-array model.
// Each test task drives accesses and compares results inline.
module tb_dmem_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_ready;
    logic [31:0] rdata;
    logic        misaligned;

    logic [7:0]  mb [4096];
    logic [31:0] m_rdata = '0;
    int          vecs = 0;
    int          errs = 0;

    logic [31:0] gr, er;
    logic        gm, em, ga;
    int          lc;

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rstN(rstN), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .funct3(funct3),
        .mem_ready(mem_ready), .rdata(rdata), .misaligned(misaligned)
    );

    // Drive one access, observe DUT, and update the reference model.
    task automatic acc(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output logic [31:0] o_gr, output logic [31:0] o_er,
                       output logic o_gm, output logic o_em,
                       output logic o_ga, output int o_lc);
        int sz;
        int b;
        logic [31:0] v;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = wd; funct3 = f3;
        @(posedge clk);
        o_lc = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (!mem_ready) o_lc++;
            addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        end
        @(negedge clk);
        if (!mem_ready) o_lc += 100;
        o_gr = rdata; o_gm = misaligned;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        if (!mem_ready) o_lc += 100;
        o_ga = misaligned;
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            default:        sz = 4;
        endcase
        b = int'(a[11:0]);
        o_em = (b % sz) != 0;
        if (rd) begin
            v = '0;
            if (!o_em) for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[b+i];
            if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
            m_rdata = o_em ? 32'd0 : v;
        end else if (wr && !o_em) begin
            for (int i = 0; i < sz; i++) mb[b+i] = wd[8*i +: 8];
        end
        o_er = m_rdata;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (mem_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", mem_ready); end
        vecs++;
        if (rdata !== 32'd0) begin errs++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        vecs++;
        if (misaligned !== 1'b0) begin errs++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        @(negedge clk) rstN = 1'b1;
        @(negedge clk);
        vecs++;
        if (mem_ready !== 1'b1) begin errs++; $display("FAIL post_reset_ready: got %b want 1", mem_ready); end
    endtask

    task automatic init_mem;
        for (int w = 0; w < 1024; w++)
            acc(0, 1, 32'(w * 4), $urandom, 3'b010, gr, er, gm, em, ga, lc);
    endtask

    task automatic test_lw;
        acc(0, 1, 32'h40, 32'hDEADBEEF, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (lc !== LAT) begin errs++; $display("FAIL sw_latency: got %0d want %0d", lc, LAT); end
        acc(1, 0, 32'h40, 32'h0, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (lc !== LAT) begin errs++; $display("FAIL lw_latency: got %0d want %0d", lc, LAT); end
        vecs++;
        if (gr !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_data: got %h want deadbeef", gr); end
    endtask

    task automatic test_byte;
        acc(0, 1, 32'h40, 32'h11223344, 3'b010, gr, er, gm, em, ga, lc);
        acc(0, 1, 32'h41, 32'hAAAAAA80, 3'b000, gr, er, gm, em, ga, lc);
        acc(1, 0, 32'h40, 32'h0, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'h11228044) begin errs++; $display("FAIL sb_merge: got %h want 11228044", gr); end
        acc(1, 0, 32'h41, 32'h0, 3'b000, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'hFFFFFF80) begin errs++; $display("FAIL lb: got %h want ffffff80", gr); end
        acc(1, 0, 32'h41, 32'h0, 3'b100, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'h00000080) begin errs++; $display("FAIL lbu: got %h want 00000080", gr); end
    endtask

    task automatic test_half;
        acc(0, 1, 32'h42, 32'h5555F00D, 3'b001, gr, er, gm, em, ga, lc);
        acc(1, 0, 32'h40, 32'h0, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'hF00D8044) begin errs++; $display("FAIL sh_merge: got %h want f00d8044", gr); end
        acc(1, 0, 32'h42, 32'h0, 3'b001, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'hFFFFF00D) begin errs++; $display("FAIL lh: got %h want fffff00d", gr); end
        acc(1, 0, 32'h42, 32'h0, 3'b101, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'h0000F00D) begin errs++; $display("FAIL lhu: got %h want 0000f00d", gr); end
    endtask

    task automatic test_misaligned;
        acc(1, 0, 32'h43, 32'h0, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'd0) begin errs++; $display("FAIL mis_lw_data: got %h want 0", gr); end
        vecs++;
        if (gm !== 1'b1) begin errs++; $display("FAIL mis_lw_pulse: got %b want 1", gm); end
        vecs++;
        if (ga !== 1'b0) begin errs++; $display("FAIL mis_lw_width: got %b want 0", ga); end
        vecs++;
        if (lc !== LAT) begin errs++; $display("FAIL mis_lw_latency: got %0d want %0d", lc, LAT); end
        acc(0, 1, 32'h41, 32'h0000BEEF, 3'b001, gr, er, gm, em, ga, lc);
        vecs++;
        if (gm !== 1'b1) begin errs++; $display("FAIL mis_sh_pulse: got %b want 1", gm); end
        vecs++;
        if (gr !== 32'd0) begin errs++; $display("FAIL mis_sh_rdata_hold: got %h want 0", gr); end
        acc(1, 0, 32'h40, 32'h0, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'hF00D8044) begin errs++; $display("FAIL mis_sh_nowrite: got %h want f00d8044", gr); end
        vecs++;
        if (gm !== 1'b0) begin errs++; $display("FAIL aligned_no_pulse: got %b want 0", gm); end
    endtask

    task automatic test_both;
        acc(1, 1, 32'h40, 32'h12345678, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'hF00D8044) begin errs++; $display("FAIL both_read: got %h want f00d8044", gr); end
        acc(1, 0, 32'h40, 32'h0, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'hF00D8044) begin errs++; $display("FAIL both_nowrite: got %h want f00d8044", gr); end
    endtask

    task automatic test_back_to_back;
        logic exp;
        @(negedge clk);
        mem_read = 1'b1; addr = 32'h40; funct3 = 3'b010;
        @(posedge clk);
        for (int i = 1; i <= 2 * (LAT + 2); i++) begin
            @(negedge clk);
            exp = ((i - 1) % (LAT + 2)) >= LAT;
            vecs++;
            if (mem_ready !== exp) begin
                errs++;
                $display("FAIL b2b_ready[%0d]: got %b want %b", i, mem_ready, exp);
            end
            if (i == 2 * (LAT + 2) - 1) begin
                vecs++;
                if (rdata !== 32'hF00D8044) begin errs++; $display("FAIL b2b_data: got %h want f00d8044", rdata); end
                mem_read = 1'b0;
            end
        end
    endtask

    task automatic test_wrap;
        acc(0, 1, 32'h1000, 32'hCAFEF00D, 3'b010, gr, er, gm, em, ga, lc);
        acc(1, 0, 32'h0, 32'h0, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== 32'hCAFEF00D) begin errs++; $display("FAIL wrap: got %h want cafef00d", gr); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h80; wdata = 32'h0BADF00D; funct3 = 3'b010;
        @(posedge clk);
        #3 rstN = 1'b0;
        #1;
        vecs++;
        if (mem_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready: got %b want 1", mem_ready); end
        vecs++;
        if (rdata !== 32'd0) begin errs++; $display("FAIL rst_mid_rdata: got %h want 0", rdata); end
        mem_write = 1'b0;
        m_rdata = '0;
        @(negedge clk) rstN = 1'b1;
        acc(1, 0, 32'h80, 32'h0, 3'b010, gr, er, gm, em, ga, lc);
        vecs++;
        if (gr !== er) begin errs++; $display("FAIL rst_mid_nowrite: got %h want %h", gr, er); end
        vecs++;
        if (lc !== LAT) begin errs++; $display("FAIL rst_mid_next: got %0d want %0d", lc, LAT); end
    endtask

    task automatic test_random;
        logic [2:0] rf [8];
        logic [2:0] wf [6];
        int op;
        logic [31:0] a;
        logic [2:0] f;
        rf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        wf = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 2);
            a = {18'd0, 14'($urandom)};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            f = (op == 1) ? wf[$urandom_range(0, 5)] : rf[$urandom_range(0, 7)];
            acc(op != 1, op != 0, a, $urandom, f, gr, er, gm, em, ga, lc);
            vecs++;
            if (gr !== er) begin errs++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, gr, er); end
            vecs++;
            if (gm !== em) begin errs++; $display("FAIL rnd_mis[%0d]: got %b want %b", n, gm, em); end
            vecs++;
            if (lc !== LAT || ga !== 1'b0) begin
                errs++;
                $display("FAIL rnd_hs[%0d]: low %0d pulse_after %b want %0d 0", n, lc, ga, LAT);
            end
        end
    endtask

    initial begin
        test_reset;
        init_mem;
        test_lw;
        test_byte;
        test_half;
        test_misaligned;
        test_both;
        test_back_to_back;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the pipelined RISC-V core: it sits at the EX/MEM boundary and services the load/store requests that the hazard unit stalls the pipeline for. It accepts one request at a time and runs a configurable fixed-latency access into an internal word-organised store. It handles RV32I byte, halfword and word sizes with sign or zero extension. It signals completion with the `mem_ready` handshake: ready drops low for the access, then returns high with load data valid.

## Interface
Parameters:
- `DATA_W`, 32: data width; fixed at 32 for RV32I.
- `ADDR_W`, 32: byte address width.
- `DEPTH`, 1024: number of 32-bit words in the store; power of two.
- `LATENCY`, 2: cycles `mem_ready` is held low per access; must be ≥1.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rstN` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: load request (level).
- `mem_write` in 1: store request (level).
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data; the low bytes are used for sb/sh.
- `funct3` in 3: size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw.
- `mem_ready` out 1: high means idle or done; low means an access is in progress.
- `rdata` out 32: extended load result.
- `misaligned` out 1: one-cycle error pulse at completion of a misaligned access.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE** (`mem_ready`=1):
  - If `mem_read` or `mem_write` is high at a clock edge, latch `addr`, `wdata`, `funct3` and the op, load `cnt` with LATENCY-1, and go to BUSY.
  - If both are high, the read wins and no write occurs.
- **BUSY** (`mem_ready`=0):
  - If `cnt`≠0, decrement `cnt` each cycle.
  - If `cnt`==0, perform the access at that edge and go to DONE.
  - Inputs are ignored while in BUSY; only the latched copies are used.
- **DONE** (`mem_ready`=1):
  - `rdata` is valid; `misaligned` is high for this cycle only when it applies.
  - Unconditionally go to IDLE next.
  - A request still held high in the following IDLE cycle starts a new access; upstream deasserts the request after the handshake.
- **Word index:** `addr[2+log2(DEPTH)-1:2]`. Upper bits are ignored, so addresses wrap modulo DEPTH×4 bytes.
- **Loads:**
  - Byte lane is selected by `addr[1:0]`; halfword lane by `addr[1]`.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
- **Stores:** byte-enable merge into the word.
  - sb writes lane `addr[1:0]` with `wdata[7:0]`.
  - sh writes the lanes selected by `addr[1]` with `wdata[15:0]`.
  - sw writes all four bytes.
  - Unselected bytes are unchanged.
- **Misaligned accesses:** lh/lhu/sh with `addr[0]`=1, or lw/sw with `addr[1:0]`≠0.
  - The handshake still runs the full latency.
  - No array write occurs; `rdata` is driven 0 for a misaligned load.
  - `misaligned` pulses in DONE.
- **Unused funct3 values:** 011, 110 and 111 behave as lw/sw.
- **`rdata` hold:** `rdata` holds its value until the next load completes; stores do not alter it.

## Timing
- **Handshake latency:** request sampled at edge t0.
  - `mem_ready` is low for cycles t0+1 … t0+LATENCY.
  - `mem_ready` is high in the DONE cycle t0+LATENCY+1, with `rdata` valid.
  - Back-to-back: the earliest next request is sampled in the IDLE cycle after DONE, giving a throughput of one access per LATENCY+2 cycles.
- **Store timing:** the write is committed at the BUSY→DONE edge. A load issued afterwards observes the new data.
- **Reset values:** state IDLE, `mem_ready`=1, `rdata`=0, `misaligned`=0, `cnt`=0.
- **Reset mid-access:** async reset in BUSY aborts the access immediately. No write is committed, and outputs return to their reset values without waiting for a clock.
- **Array contents:** not reset; contents are undefined until written.

## Test plan
- **lw:** sw 0xDEADBEEF to 0x40, then lw from 0x40, LATENCY=2 → `mem_ready` low exactly 2 cycles, then high with `rdata`=0xDEADBEEF.
- **sb / lb / lbu:** sb 0x80 to 0x41 over word 0x11223344 → word becomes 0x11228044; lb 0x41 → 0xFFFFFF80; lbu 0x41 → 0x00000080.
- **sh / lh / lhu:** sh 0xF00D to 0x42 → word 0xF00D8044; lh 0x42 → 0xFFFFF00D; lhu 0x42 → 0x0000F00D.
- **Misaligned:** lw at 0x43, and sh at 0x41 → full handshake, `misaligned` one-cycle pulse, memory unchanged, `rdata`=0 after the load.
- **Simultaneous request and wrap-around:** `mem_read` and `mem_write` both high → read only, memory unchanged. With DEPTH=1024, sw to 0x1000 then lw 0x0 → same data.
- **Reset mid-access:** assert `rstN`=0 during BUSY of an sw → `mem_ready`=1 immediately, target word unchanged, next access completes normally.
